result_drain: RTL
=================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset, named as below; no other clock or reset exists.
REQ-002 SHALL expose these ports:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-low reset
  start  in  1  1-cycle request to begin a drain; sampled only in IDLE
  base_addr  in  16  byte address of first output word; sampled with start
  word_count  in  10  words to drain, 0..1023; sampled with start
  read_result_signal  out  1  read strobe to local result memory
  read_result_addr  out  10  word index into local result memory
  read_result_data  in  32  local memory read data, valid in the same cycle as the strobe
  out_valid  out  1  output word/address valid
  out_ready  in  1  downstream accept
  out_addr  out  16  byte address of current output word
  out_data  out  32  current output word
  busy  out  1  high in any state other than IDLE
  done  out  1  1-cycle completion pulse

Function
REQ-003 SHALL implement the FSM states IDLE, READ, SEND and FIN, with exactly one state active per cycle.
REQ-004 IDLE: start=1 with word_count>0 SHALL latch base_addr and word_count, clear index to 0, and go to READ; start=1 with word_count=0 SHALL go directly to FIN.
REQ-005 READ: SHALL assert read_result_signal=1 with read_result_addr=index for exactly one cycle, capture read_result_data into the out_data register, and go to SEND.
REQ-006 SEND: SHALL hold out_valid=1 and SHALL keep out_addr and out_data stable until out_ready=1.
REQ-007 SEND with out_ready=1 (the transfer cycle): if index=count-1, SHALL go to FIN; otherwise SHALL increment index and go to READ.
REQ-008 FIN: SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-009 out_addr SHALL equal latched base_addr + 4*index, computed modulo 2^16; wrap past 16'hFFFC SHALL continue at 16'h0000 without error.
REQ-010 read_result_signal SHALL be 0 and read_result_addr SHALL be 0 outside READ.
REQ-011 out_valid SHALL be 0 outside SEND.
REQ-012 Throughput: with out_ready held at 1, each word SHALL take 2 cycles (READ+SEND); a drain of N>0 words SHALL raise done exactly 2N+1 cycles after the start cycle.
REQ-013 start asserted while busy=1 SHALL be ignored, with no effect on latched parameters or counters.
REQ-014 Changes to base_addr or word_count after the start cycle SHALL NOT affect the drain in progress.
REQ-015 out_ready asserted while out_valid=0 SHALL be ignored.
REQ-016 start=1 in the same cycle that FIN returns to IDLE SHALL NOT be accepted; start is accepted only while the FSM is in IDLE.

Reset
REQ-017 rst=0 at a rising clk edge SHALL force IDLE, index=0, latched count=0, latched address=0, out_data=0, and drive every output to 0.
REQ-018 Reset asserted mid-drain SHALL abort without a done pulse; after rst returns to 1, the block SHALL wait in IDLE for a new start.
REQ-019 While rst=0, start SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  V1: base_addr=16'h0100, word_count=3, out_ready=1, memory returns A,B,C -> out sequence (0100,A),(0104,B),(0108,C); done pulses 7 cycles after start.
  V2: word_count=0 -> no read strobe, no out_valid; done 1 cycle after start; busy high for 1 cycle.
  V3: word_count=2, out_ready held 0 for 5 cycles on word 0 -> out_valid, out_addr and out_data stable for 6 cycles; only 2 read strobes total.
  V4: base_addr=16'hFFF8, word_count=4 -> out_addr FFF8, FFFC, 0000, 0004.
  V5: start re-pulsed with word_count=5 during a 3-word drain -> exactly 3 transfers, one done pulse.
  V6: rst=0 during SEND of word 1 -> next cycle all outputs 0 and no done pulse; a new start with word_count=1 then completes normally in 3 cycles.

Source files
------------

// File: rtl/result_drain.sv
// result_drain: walks word_count entries of a local result memory and
// presents each as an (address, data) beat on a valid/ready output port.
// Every word costs one READ cycle and at least one SEND cycle; a FIN cycle
// pulses done. All outputs come straight from registers.
module result_drain (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [9:0]  word_count,
  output logic        read_result_signal,
  output logic [9:0]  read_result_addr,
  input  logic [31:0] read_result_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_base;
  logic [9:0]  r_cnt;
  logic [9:0]  r_idx;
  logic        r_rd;
  logic [9:0]  r_rd_addr;
  logic        r_valid;
  logic [15:0] r_addr;
  logic [31:0] r_data;
  logic        r_busy;
  logic        r_done;

  logic        w_last;
  logic [9:0]  w_idx_nxt;
  logic [15:0] w_word_addr;

  // Byte address of the current word; the 16-bit add wraps naturally.
  assign w_word_addr = r_base + {4'b0000, r_idx, 2'b00};
  assign w_idx_nxt   = r_idx + 10'd1;
  // r_cnt is never 0 while a word is in flight, so count-1 cannot underflow.
  assign w_last      = (r_idx == (r_cnt - 10'd1));

  // Drain sequencer: state, latched parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rd      <= 1'b0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (word_count != 10'd0) begin
              r_base    <= base_addr;
              r_cnt     <= word_count;
              r_idx     <= '0;
              r_rd      <= 1'b1;
              r_rd_addr <= '0;
              r_state   <= S_READ;
            end else begin
              // Empty drain: nothing to read, just report completion.
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_READ: begin
          // Memory data is valid alongside the strobe; capture it here.
          r_rd      <= 1'b0;
          r_rd_addr <= '0;
          r_data    <= read_result_data;
          r_addr    <= w_word_addr;
          r_valid   <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          // Hold the beat until the consumer takes it.
          if (out_ready) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_idx     <= w_idx_nxt;
              r_rd      <= 1'b1;
              r_rd_addr <= w_idx_nxt;
              r_state   <= S_READ;
            end
          end
        end
        S_FIN: begin
          // start is not sampled here, so a request in this cycle is dropped.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_result_signal = r_rd;
  assign read_result_addr   = r_rd_addr;
  assign out_valid          = r_valid;
  assign out_addr           = r_addr;
  assign out_data           = r_data;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule
